nfu_add_acc_piped: RTL and testbench



---
 rtl/nfu_add_acc_piped.sv | 131 +++++++++++++
 tb/tb_nfu_add_acc_piped.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/nfu_add_acc_piped.sv
// rtl/nfu_add_acc_piped.sv - registered adder tree plus group accumulator with saturating output
module nfu_add_acc_piped #(
  parameter int N      = 16,
  parameter int TN     = 16,
  parameter int LOG_TN = 4,
  parameter int ACC_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [TN*N-1:0] prod_in,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic [N-1:0]    sum_out,
  output logic            sat_out,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

  logic en;
  logic out_valid_q, out_valid_d;
  logic sat_q, sat_d;
  logic [N-1:0] sum_q, sum_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic first_q, first_d;

  // A pending output that the consumer refuses freezes the whole pipeline.
  assign en       = !(out_valid_q && !out_ready);
  assign in_ready = en;

  for (genvar k = 1; k <= LOG_TN; k++) begin : g_st
    localparam int W   = N + k;
    localparam int CNT = TN >> k;
    logic signed [W-1:0] sum_d_s [CNT];
    logic signed [W-1:0] sum_q_s [CNT];
    logic vld_d, last_d, vld_q, last_q;

    if (k == 1) begin : g_in
      for (genvar i = 0; i < CNT; i++) begin : g_add
        logic [N-1:0] a, b;
        assign a = prod_in[2*i*N +: N];
        assign b = prod_in[(2*i+1)*N +: N];
        assign sum_d_s[i] = {a[N-1], a} + {b[N-1], b};
      end
      assign vld_d  = in_valid && en;
      assign last_d = in_valid && in_last;
    end else begin : g_mid
      for (genvar i = 0; i < CNT; i++) begin : g_add
        assign sum_d_s[i] = {g_st[k-1].sum_q_s[2*i][W-2],   g_st[k-1].sum_q_s[2*i]}
                          + {g_st[k-1].sum_q_s[2*i+1][W-2], g_st[k-1].sum_q_s[2*i+1]};
      end
      assign vld_d  = g_st[k-1].vld_q;
      assign last_d = g_st[k-1].last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        last_q <= 1'b0;
        for (int j = 0; j < CNT; j++) sum_q_s[j] <= '0;
      end else if (en) begin
        vld_q   <= vld_d;
        last_q  <= last_d;
        sum_q_s <= sum_d_s;
      end
    end
  end

  logic signed [N+LOG_TN-1:0] tree_sum;
  logic tree_vld, tree_last;
  logic signed [ACC_W-1:0] tree_ext, acc_base, acc_next;

  assign tree_sum  = g_st[LOG_TN].sum_q_s[0];
  assign tree_vld  = g_st[LOG_TN].vld_q;
  assign tree_last = g_st[LOG_TN].last_q;
  assign tree_ext  = ACC_W'(tree_sum);
  assign acc_base  = first_q ? '0 : acc_q;
  assign acc_next  = acc_base + tree_ext;

  always_comb begin
    acc_d       = acc_q;
    first_d     = first_q;
    sum_d       = sum_q;
    sat_d       = sat_q;
    out_valid_d = en ? 1'b0 : out_valid_q;
    if (en && tree_vld) begin
      if (tree_last) begin
        out_valid_d = 1'b1;
        acc_d       = '0;
        first_d     = 1'b1;
        if (acc_next > SAT_MAX) begin
          sum_d = SAT_MAX[N-1:0];
          sat_d = 1'b1;
        end else if (acc_next < SAT_MIN) begin
          sum_d = SAT_MIN[N-1:0];
          sat_d = 1'b1;
        end else begin
          sum_d = acc_next[N-1:0];
          sat_d = 1'b0;
        end
      end else begin
        acc_d   = acc_next;
        first_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      first_q     <= 1'b1;
      sum_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      first_q     <= first_d;
      sum_q       <= sum_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum_out   = sum_q;
  assign sat_out   = sat_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_nfu_add_acc_piped.sv
// tb/tb_nfu_add_acc_piped.sv - directed self-checking bench for nfu_add_acc_piped
module tb_nfu_add_acc_piped;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] prod_in;
  logic         in_valid, in_last, in_ready;
  logic [15:0]  sum_out;
  logic         sat_out, out_valid, out_ready;

  int total = 0;
  int bad   = 0;
  logic [16:0] res_q[$];

  nfu_add_acc_piped #(.N(16), .TN(16), .LOG_TN(4), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .sum_out(sum_out),
    .sat_out(sat_out), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Record every output handoff exactly once.
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) res_q.push_back({sat_out, sum_out});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] fill(input logic [15:0] v);
    return {16{v}};
  endfunction

  task automatic send(input logic [255:0] d, input logic last);
    logic rdy;
    int   n;
    prod_in  = d;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 200);
    if (!rdy) chk("send_timeout", 32'd0, 32'd1);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic get_result(input string tag, input logic [15:0] es, input logic esat);
    logic [16:0] r;
    int n = 0;
    while (res_q.size() == 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (res_q.size() == 0) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      r = res_q.pop_front();
      chk({tag, "_sum"}, 32'(r[15:0]), 32'(es));
      chk({tag, "_sat"}, 32'(r[16]), 32'(esat));
    end
  endtask

  initial begin
    logic [255:0] mixed;
    int lat;
    mixed     = {{8{16'h0003}}, {8{16'hFFFF}}};
    rst_n     = 1'b0;
    prod_in   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",       32'(sum_out),   32'd0);
    chk("rst_sat",       32'(sat_out),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;

    send(fill(16'h0001), 1'b1);
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
      @(posedge clk);
    end
    chk("t1_latency", 32'(lat), 32'd5);
    get_result("t1", 16'h0010, 1'b0);
    idle(2);

    send(fill(16'h0100), 1'b0);
    send(fill(16'h0100), 1'b0);
    send(fill(16'h0100), 1'b1);
    idle(10);
    chk("t2_count", 32'(res_q.size()), 32'd1);
    get_result("t2", 16'h3000, 1'b0);

    for (int i = 0; i < 16; i++) send(fill(16'h7FFF), i == 15);
    get_result("t3", 16'h7FFF, 1'b1);

    send(fill(16'h8000), 1'b1);
    get_result("t4", 16'h8000, 1'b1);

    send(mixed, 1'b1);
    get_result("t5", 16'h0010, 1'b0);

    send(mixed, 1'b0);
    idle(3);
    send(mixed, 1'b1);
    get_result("t6", 16'h0020, 1'b0);
    idle(5);

    res_q.delete();
    out_ready = 1'b0;
    send(fill(16'h0001), 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("t7_wait_valid", 32'(out_valid), 32'd1);
    fork
      send(fill(16'h0002), 1'b1);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("t7_hold_sum",   32'(sum_out),   32'h0010);
          chk("t7_hold_valid", 32'(out_valid), 32'd1);
          chk("t7_in_ready",   32'(in_ready),  32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(10);
    chk("t7_count", 32'(res_q.size()), 32'd2);
    get_result("t7a", 16'h0010, 1'b0);
    get_result("t7b", 16'h0020, 1'b0);

    res_q.delete();
    send(fill(16'h0100), 1'b0);
    send(fill(16'h0100), 1'b0);
    #2 rst_n = 1'b0;
    #3;
    chk("t8_rst_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(fill(16'h0001), 1'b1);
    idle(10);
    chk("t8_count", 32'(res_q.size()), 32'd1);
    get_result("t8", 16'h0010, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
